// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared types and default widths for the RCC buffer helpers.
//   FIFO_Writer_Help_state : state encoding of fifo_writer_helper
//   FWH_*                  : default parameter values for fifo_writer_helper
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_WRITE   = 2'd2,
    W_DONE    = 2'd3
  } FIFO_Writer_Help_state;

  localparam int unsigned FWH_DATA_W = 32;
  localparam int unsigned FWH_BYTE_W = 8;
  localparam int unsigned FWH_LEN_W  = 6;

endpackage

// File: rtl/fifo_writer_helper.sv
// ---------------------------------------------------------------------------
// fifo_writer_helper
// Packs a byte stream (lane 0 = least significant byte) into DATA_W-bit words
// and writes them to the RCC buffer FIFO. One transfer of
// i_RCC_BUFFER_LENGTH bytes is taken per Write_Request; the last partial word
// is zero-padded and o_done pulses for one cycle after the final write.
//
// Ports
//   CLK, RESETn              clock (rising edge), async active-low reset
//   Write_Request            start pulse, only looked at while idle
//   i_RCC_BUFFER_LENGTH      transfer length in bytes, latched at start
//   serialized_input(_valid) byte stream in
//   o_serialized_ready       byte taken when valid && ready
//   i_FIFO_prog_full         FIFO back-pressure, blocks the write
//   o_FIFO_din / o_FIFO_wr_en assembled word and its write strobe
//   o_done                   one-cycle end-of-transfer pulse
//   Deserialize_Counter      lane the next byte will land in
// ---------------------------------------------------------------------------
module fifo_writer_helper
  import ahb3lite_pkg::*;
#(
  parameter int DATA_W = FWH_DATA_W,
  parameter int BYTE_W = FWH_BYTE_W,
  parameter int LEN_W  = FWH_LEN_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              Write_Request,
  input  logic [LEN_W-1:0]  i_RCC_BUFFER_LENGTH,
  input  logic [BYTE_W-1:0] serialized_input,
  input  logic              serialized_input_valid,
  output logic              o_serialized_ready,
  input  logic              i_FIFO_prog_full,
  output logic [DATA_W-1:0] o_FIFO_din,
  output logic              o_FIFO_wr_en,
  output logic              o_done,
  output logic [1:0]        Deserialize_Counter
);

  localparam int LANES = DATA_W / BYTE_W;

  FIFO_Writer_Help_state state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            lane_q, lane_d;
  logic [DATA_W-1:0]     word_q, word_d;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= W_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic and output decode. Outputs depend only on registered
  // state, except wr_en which is additionally gated by prog_full.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    word_d  = word_q;

    o_serialized_ready  = (state_q == W_COLLECT);
    o_FIFO_wr_en        = (state_q == W_WRITE) && !i_FIFO_prog_full;
    o_FIFO_din          = (state_q == W_WRITE) ? word_q : '0;
    o_done              = (state_q == W_DONE);
    Deserialize_Counter = lane_q;

    case (state_q)
      W_IDLE: begin
        // A zero-length request would never produce a word, so it is dropped.
        if (Write_Request && (i_RCC_BUFFER_LENGTH != '0)) begin
          len_d   = i_RCC_BUFFER_LENGTH;
          cnt_d   = '0;
          lane_d  = '0;
          word_d  = '0;
          state_d = W_COLLECT;
        end
      end
      W_COLLECT: begin
        if (serialized_input_valid) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_q == 2'(l)) begin
              word_d[l*BYTE_W +: BYTE_W] = serialized_input;
            end
          end
          cnt_d  = cnt_q + LEN_W'(1);
          lane_d = lane_q + 2'd1;
          // Flush on a full word or on the last byte of the transfer.
          if ((lane_q == 2'd3) || (cnt_d == len_q)) begin
            state_d = W_WRITE;
          end
        end
      end
      W_WRITE: begin
        if (!i_FIFO_prog_full) begin
          word_d  = '0;
          lane_d  = '0;
          state_d = (cnt_q == len_q) ? W_DONE : W_COLLECT;
        end
      end
      W_DONE: begin
        state_d = W_IDLE;
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase
  end

endmodule
